// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : daq_pkg
// Description : Shared types and constants for the AD7606 DAQ read sequencer:
//               FSM state encoding, sample word width, header marker nibble
//               and a small helper used to size counters.
// Revision    : 1.0 - initial release
// ============================================================================
package daq_pkg;

  localparam int DAQ_WORD_W = 16;
  localparam logic [3:0] HEADER_MARKER = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CONV    = 4'd1,
    S_WAIT_HI = 4'd2,
    S_WAIT_LO = 4'd3,
    S_RD_LOW  = 4'd4,
    S_RD_HIGH = 4'd5,
    S_NEXT    = 4'd6,
    S_DONE    = 4'd7,
    S_ABORT   = 4'd8
  } state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/daq_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : daq_read_sequencer_if
// Description : ADC bus and FIFO write port bundle for the DAQ read sequencer.
//   busy        ADC -> seq   asynchronous BUSY, one bit per ADC
//   db          ADC -> seq   shared 16-bit data bus
//   convst      seq -> ADC   conversion start, idle high
//   cs_n        seq -> ADC   active-low chip selects
//   rd_n        seq -> ADC   active-low read strobe
//   fifo_data   seq -> FIFO  write data
//   fifo_wrreq  seq -> FIFO  write strobe
//   fifo_wrfull FIFO -> seq  FIFO full
//   master = sequencer side, slave = ADC/FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface daq_read_sequencer_if #(
  parameter int ADC_COUNT = 4
) ();
  import daq_pkg::*;

  logic [ADC_COUNT-1:0]  busy;
  logic [DAQ_WORD_W-1:0] db;
  logic                  convst;
  logic [ADC_COUNT-1:0]  cs_n;
  logic                  rd_n;
  logic [DAQ_WORD_W-1:0] fifo_data;
  logic                  fifo_wrreq;
  logic                  fifo_wrfull;

  modport master (
    input  busy, db, fifo_wrfull,
    output convst, cs_n, rd_n, fifo_data, fifo_wrreq
  );

  modport slave (
    output busy, db, fifo_wrfull,
    input  convst, cs_n, rd_n, fifo_data, fifo_wrreq
  );
endinterface
`default_nettype wire

// File: rtl/daq_busy_sync.sv
`default_nettype none
// ============================================================================
// Module      : daq_busy_sync
// Description : Two-flop synchroniser for the ADC BUSY lines plus OR / NOR
//               reduction.
//   clk_i, reset_i  clock and synchronous active-high reset
//   busy_async      raw BUSY inputs (ADC_COUNT bits)
//   any_busy        at least one synchronised BUSY is high
//   all_idle        all synchronised BUSY bits are low
// Revision    : 1.0 - initial release
// ============================================================================
module daq_busy_sync #(
  parameter int ADC_COUNT = 4
) (
  input  wire logic                 clk_i,
  input  wire logic                 reset_i,
  input  wire logic [ADC_COUNT-1:0] busy_async,
  output logic                      any_busy,
  output logic                      all_idle
);

  logic [ADC_COUNT-1:0] r_meta;
  logic [ADC_COUNT-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= busy_async;
      r_sync <= r_meta;
    end
  end

  assign any_busy = |r_sync;
  assign all_idle = ~|r_sync;

endmodule
`default_nettype wire

// File: rtl/daq_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : daq_read_sequencer
// Description : Frame controller for a bank of AD7606 ADCs on a shared bus.
//               Pulses CONVST, waits for BUSY high then low (with timeout),
//               then reads CHANNELS words from each ADC in turn and writes
//               them to the DAQ FIFO. Drops on FIFO full set a sticky overrun.
//   clk_i, reset_i     clock and synchronous active-high reset
//   en_i, trig_i       trigger enable and single-cycle frame start
//   bus (master)       ADC bus and FIFO write port
//   active_o, done_o   frame in progress / one-cycle completion pulse
//   overrun_o          sticky word-dropped flag
//   timeout_o          sticky busy-edge timeout flag
// Build option : DAQ_HEADER_EN - prefix every frame with {4'hA, frame_cnt}.
// Revision    : 1.0 - initial release
// ============================================================================
module daq_read_sequencer
  import daq_pkg::*;
#(
  parameter int ADC_COUNT         = 4,
  parameter int CHANNELS          = 8,
  parameter int RD_LOW_CYCLES     = 4,
  parameter int RD_HIGH_CYCLES    = 3,
  parameter int CONV_PULSE_CYCLES = 5,
  parameter int BUSY_TIMEOUT      = 1000
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  input  wire logic en_i,
  input  wire logic trig_i,
  daq_read_sequencer_if.master bus,
  output logic      active_o,
  output logic      done_o,
  output logic      overrun_o,
  output logic      timeout_o
);

  localparam int CNT_MAX = imax(imax(RD_LOW_CYCLES, RD_HIGH_CYCLES),
                                imax(CONV_PULSE_CYCLES, BUSY_TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ADC_W   = (ADC_COUNT > 1) ? $clog2(ADC_COUNT) : 1;
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADC_W-1:0]      r_adc;
  logic [CH_W-1:0]       r_ch;
  logic                  r_convst;
  logic [ADC_COUNT-1:0]  r_cs_n;
  logic                  r_rd_n;
  logic [DAQ_WORD_W-1:0] r_fifo_data;
  logic                  r_fifo_wrreq;
  logic                  r_active;
  logic                  r_done;
  logic                  r_overrun;
  logic                  r_timeout;
`ifdef DAQ_HEADER_EN
  logic [11:0]           r_frame_cnt;
`endif

  logic w_any_busy;
  logic w_all_idle;

  daq_busy_sync #(.ADC_COUNT(ADC_COUNT)) u_busy_sync (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .busy_async (bus.busy),
    .any_busy   (w_any_busy),
    .all_idle   (w_all_idle)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_adc        <= '0;
      r_ch         <= '0;
      r_convst     <= 1'b1;
      r_cs_n       <= '1;
      r_rd_n       <= 1'b1;
      r_fifo_data  <= '0;
      r_fifo_wrreq <= 1'b0;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
`ifdef DAQ_HEADER_EN
      r_frame_cnt  <= '0;
`endif
    end else begin
      r_fifo_wrreq <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (trig_i && en_i) begin
            r_state  <= S_CONV;
            r_active <= 1'b1;
            r_convst <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_CONV: begin
          if (r_cnt == CNT_W'(CONV_PULSE_CYCLES - 1)) begin
            r_convst <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WAIT_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_HI: begin
          // The first cycle here is the CONVST rise cycle, so the
          // timeout window is measured from that rise.
          if (w_any_busy) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_LO;
          end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_ABORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (w_all_idle) begin
            r_adc   <= '0;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_cs_n  <= ~ADC_COUNT'(1);
            r_rd_n  <= 1'b0;
            r_state <= S_RD_LOW;
`ifdef DAQ_HEADER_EN
            // Header goes out while the first read strobe starts, so the
            // read phase timing is unchanged by the header.
            r_fifo_data <= {HEADER_MARKER, r_frame_cnt};
            if (bus.fifo_wrfull) r_overrun    <= 1'b1;
            else                 r_fifo_wrreq <= 1'b1;
`endif
          end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_ABORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_LOW: begin
          if (r_cnt == CNT_W'(RD_LOW_CYCLES - 1)) begin
            r_cnt       <= '0;
            r_rd_n      <= 1'b1;
            r_state     <= S_RD_HIGH;
            r_fifo_data <= bus.db;
            if (bus.fifo_wrfull) r_overrun    <= 1'b1;
            else                 r_fifo_wrreq <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_HIGH: begin
          if (r_cnt == CNT_W'(RD_HIGH_CYCLES - 1)) begin
            r_cnt <= '0;
            if (r_ch == CH_W'(CHANNELS - 1)) begin
              r_cs_n  <= '1;
              r_state <= S_NEXT;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_rd_n  <= 1'b0;
              r_state <= S_RD_LOW;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (r_adc == ADC_W'(ADC_COUNT - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_adc   <= r_adc + 1'b1;
            r_ch    <= '0;
            r_cs_n  <= ~(ADC_COUNT'(1) << (r_adc + 1'b1));
            r_rd_n  <= 1'b0;
            r_state <= S_RD_LOW;
          end
        end
        S_DONE: begin
          r_active <= 1'b0;
`ifdef DAQ_HEADER_EN
          r_frame_cnt <= r_frame_cnt + 1'b1;
`endif
          r_state  <= S_IDLE;
        end
        S_ABORT: begin
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.convst     = r_convst;
  assign bus.cs_n       = r_cs_n;
  assign bus.rd_n       = r_rd_n;
  assign bus.fifo_data  = r_fifo_data;
  assign bus.fifo_wrreq = r_fifo_wrreq;
  assign active_o       = r_active;
  assign done_o         = r_done;
  assign overrun_o      = r_overrun;
  assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_daq_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_daq_read_sequencer
// Description : Directed self-checking bench for daq_read_sequencer with a
//               behavioural AD7606 bank (busy pulse, db = adc*16+ch) and a
//               FIFO-full injector. Honours DAQ_HEADER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_daq_read_sequencer;
  import daq_pkg::*;

  localparam int A  = 2;
  localparam int C  = 8;
  localparam int RL = 2;
  localparam int RH = 2;
  localparam int CP = 5;
  localparam int BT = 50;
`ifdef DAQ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic trig = 1'b0;
  logic active, done, overrun, timeout;

  int   n_pass = 0;
  int   n_total = 0;
  int   ndone = 0;
  int   full_word = -1;
  logic busy_en = 1'b1;
  logic [15:0] wq[$];
  logic [1:0]  cq[$];

  daq_read_sequencer_if #(.ADC_COUNT(A)) bus ();

  daq_read_sequencer #(
    .ADC_COUNT(A), .CHANNELS(C), .RD_LOW_CYCLES(RL), .RD_HIGH_CYCLES(RH),
    .CONV_PULSE_CYCLES(CP), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .trig_i(trig), .bus(bus),
    .active_o(active), .done_o(done), .overrun_o(overrun), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // BUSY model: 3 cycles after CONVST rises, all ADCs busy for 20 cycles.
  initial begin
    logic pc;
    pc = 1'b1;
    bus.busy = '0;
    forever begin
      @(negedge clk);
      if (!pc && bus.convst && busy_en) begin
        repeat (3) @(negedge clk);
        bus.busy = '1;
        repeat (20) @(negedge clk);
        bus.busy = '0;
      end
      pc = bus.convst;
    end
  end

  // Data bus model and FIFO-full injector.
  initial begin
    logic pconv, prd;
    int   widx, sel;
    int   chc [A];
    pconv = 1'b1; prd = 1'b1; widx = -1;
    foreach (chc[i]) chc[i] = 0;
    bus.db = '0;
    bus.fifo_wrfull = 1'b0;
    forever begin
      @(negedge clk);
      sel = (bus.cs_n[0] == 1'b0) ? 0 : 1;
      if (pconv && !bus.convst) begin
        widx = -1;
        foreach (chc[i]) chc[i] = 0;
      end
      if (prd && !bus.rd_n) begin
        widx++;
        if (widx == full_word) bus.fifo_wrfull = 1'b1;
      end
      if (!prd && bus.rd_n) begin
        bus.fifo_wrfull = 1'b0;
        chc[sel]++;
      end
      bus.db = 16'(sel * 16 + chc[sel]);
      pconv = bus.convst;
      prd = bus.rd_n;
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_wrreq) begin
      wq.push_back(bus.fifo_data);
      cq.push_back(bus.cs_n);
    end
    if (done) ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    wq.delete();
    cq.delete();
    ndone = 0;
  endtask

  task automatic pulse_trig();
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    logic seen;
    seen = active;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (active) seen = 1'b1;
      else if (seen) break;
    end
    chk({tag, "_bound"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic wait_words(input string tag, input int cnt);
    int n;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (wq.size() >= cnt) break;
    end
    chk({tag, "_wbound"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_convst"}, 32'(bus.convst), 32'd1);
    chk({tag, "_cs_n"}, 32'(bus.cs_n), 32'd3);
    chk({tag, "_rd_n"}, 32'(bus.rd_n), 32'd1);
    chk({tag, "_data"}, 32'(bus.fifo_data), 32'd0);
    chk({tag, "_wrreq"}, 32'(bus.fifo_wrreq), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int drop, input logic [11:0] fnum);
    int k;
    k = 0;
    chk({tag, "_count"}, 32'(wq.size()), 32'(16 + HDR - ((drop >= 0) ? 1 : 0)));
`ifdef DAQ_HEADER_EN
    if (wq.size() > 0) chk({tag, "_hdr"}, 32'(wq[0]), 32'({HEADER_MARKER, fnum}));
    k = 1;
`else
    if (fnum == 12'hFFF) k = 0;
`endif
    for (int i = 0; i < 16; i++) begin
      if (i != drop) begin
        if (k < wq.size()) begin
          chk($sformatf("%s_w%0d", tag, i), 32'(wq[k]), 32'((i / 8) * 16 + i % 8));
          chk($sformatf("%s_cs%0d", tag, i), 32'(cq[k]), (i < 8) ? 32'd2 : 32'd1);
        end
        k++;
      end
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;

    // Trigger with enable low is ignored.
    pulse_trig();
    repeat (10) @(negedge clk);
    chk("en_low_idle", 32'(active), 32'd0);
    en = 1'b1;

    // 1: normal frame
    clear_mon();
    pulse_trig();
    chk("t1_active", 32'(active), 32'd1);
    wait_frame("t1");
    check_frame("t1", -1, 12'd0);
    chk("t1_done", 32'(ndone), 32'd1);
    chk("t1_ovr", 32'(overrun), 32'd0);

    // 2: FIFO full during third word
    clear_mon();
    full_word = 2;
    pulse_trig();
    wait_frame("t2");
    full_word = -1;
    check_frame("t2", 2, 12'd1);
    chk("t2_done", 32'(ndone), 32'd1);
    repeat (5) @(negedge clk);
    chk("t2_ovr_hold", 32'(overrun), 32'd1);

    // 3: busy never rises
    clear_mon();
    busy_en = 1'b0;
    pulse_trig();
    for (k = 0; k < 20; k++) begin
      if (bus.convst) break;
      @(negedge clk);
    end
    chk("t3_conv_rise", 32'(k < 20), 32'd1);
    repeat (49) @(negedge clk);
    chk("t3_tmo_49", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("t3_tmo_50", 32'(timeout), 32'd1);
    wait_frame("t3");
    chk("t3_writes", 32'(wq.size()), 32'd0);
    chk("t3_done", 32'(ndone), 32'd0);
    busy_en = 1'b1;
    clear_mon();
    pulse_trig();
    wait_frame("t3b");
    check_frame("t3b", -1, 12'd2);
    chk("t3b_done", 32'(ndone), 32'd1);
    chk("t3b_tmo_hold", 32'(timeout), 32'd1);

    // 4: trigger while active
    clear_mon();
    pulse_trig();
    wait_words("t4", 5 + HDR);
    pulse_trig();
    wait_frame("t4");
    check_frame("t4", -1, 12'd3);
    chk("t4_done", 32'(ndone), 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_no_restart", 32'(active), 32'd0);
    chk("t4_no_more", 32'(wq.size()), 32'(16 + HDR));

    // 5: reset mid-frame
    clear_mon();
    pulse_trig();
    wait_words("t5", 5 + HDR);
    reset = 1'b1;
    @(negedge clk);
    check_reset("t5");
    reset = 1'b0;
    clear_mon();
    pulse_trig();
    wait_frame("t5b");
    check_frame("t5b", -1, 12'd0);
    chk("t5b_done", 32'(ndone), 32'd1);

    // 6: two more frames (header count continues from the post-reset frame)
    for (int f = 1; f <= 2; f++) begin
      clear_mon();
      pulse_trig();
      wait_frame($sformatf("t6f%0d", f));
      check_frame($sformatf("t6f%0d", f), -1, 12'(f));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
